gap_channel_sequencer: RTL and testbench

//  Sequences global average pooling over NUM_CH channels of the final 7x7 feature map.

---
 rtl/gap_channel_sequencer_pkg.sv | 21 ++
 rtl/gap_channel_sequencer_out_reg.sv | 40 ++++
 rtl/gap_channel_sequencer.sv | 168 ++++++++++++++++
 tb/tb_gap_channel_sequencer.sv | 325 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/gap_channel_sequencer_pkg.sv
// Shared types and constants for the global-average-pooling channel sequencer.
package gap_pkg;

  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    FEED,
    WAIT,
    EMIT,
    FINISH
  } gap_seq_state_e;

  // Points per channel of the final 7x7 feature map; must match the avg_pool divisor.
  localparam int GAP_POINTS_PER_CH = 49;

  // Counter width able to hold 0..n-1; never narrower than one bit.
  function automatic int gap_cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/gap_channel_sequencer_out_reg.sv
// One-entry valid/ready holding register for a channel average and its channel index.
module gap_out_reg #(
  parameter int DATA_WIDTH = 32,
  parameter int CH_WIDTH   = 10
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_load,
  input  logic [DATA_WIDTH-1:0] i_data,
  input  logic [CH_WIDTH-1:0]   i_channel,
  input  logic                  i_ready,
  output logic                  o_valid,
  output logic [DATA_WIDTH-1:0] o_data,
  output logic [CH_WIDTH-1:0]   o_channel
);

  logic                  r_valid;
  logic [DATA_WIDTH-1:0] r_data;
  logic [CH_WIDTH-1:0]   r_channel;

  // Capture on load, hold payload stable until the downstream handshake.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_valid   <= 1'b0;
      r_data    <= '0;
      r_channel <= '0;
    end else if (i_load) begin
      r_valid   <= 1'b1;
      r_data    <= i_data;
      r_channel <= i_channel;
    end else if (r_valid && i_ready) begin
      r_valid   <= 1'b0;
    end
  end

  assign o_valid   = r_valid;
  assign o_data    = r_data;
  assign o_channel = r_channel;

endmodule

// File: rtl/gap_channel_sequencer.sv
// Global average pooling sequencer: streams POINTS_PER_CH points per channel from
// feature memory into avg_pool, waits for each average and hands it downstream.
// Optional macro GAP_SEQ_TIMEOUT_EN adds a WAIT watchdog of TIMEOUT_CYC cycles.
module gap_channel_sequencer
  import gap_pkg::*;
#(
  parameter int DATA_WIDTH    = 32,
  parameter int ADDR_WIDTH    = 16,
  parameter int NUM_CH        = 1024,
  parameter int POINTS_PER_CH = GAP_POINTS_PER_CH
`ifdef GAP_SEQ_TIMEOUT_EN
  , parameter int TIMEOUT_CYC = 256
`endif
) (
  input  logic                            clock,
  input  logic                            reset,
  input  logic                            start,
  output logic                            busy,
  output logic                            done,
  output logic                            err,
  output logic                            mem_rd_en,
  output logic [ADDR_WIDTH-1:0]           mem_rd_addr,
  input  logic [DATA_WIDTH-1:0]           mem_rd_data,
  output logic                            pool_clear,
  output logic [DATA_WIDTH-1:0]           pool_point_data,
  output logic                            pool_point_valid,
  input  logic                            pool_done,
  input  logic [DATA_WIDTH-1:0]           pool_average,
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic [DATA_WIDTH-1:0]           out_data,
  output logic [gap_cnt_w(NUM_CH)-1:0]    out_channel
);

  localparam int CH_W = gap_cnt_w(NUM_CH);
  localparam int P_W  = gap_cnt_w(POINTS_PER_CH);

  gap_seq_state_e        r_state, w_next;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [CH_W-1:0]       r_ch;
  logic [P_W-1:0]        r_p;
  logic                  r_err;
  logic                  r_pt_valid;
  logic                  w_last_p, w_last_ch, w_hs, w_load, w_timeout, w_accept;

  assign w_last_p  = (r_p == P_W'(POINTS_PER_CH - 1));
  assign w_last_ch = (r_ch == CH_W'(NUM_CH - 1));
  assign w_hs      = out_valid && out_ready;
  assign w_load    = (r_state == WAIT) && pool_done;
  assign w_accept  = (r_state == IDLE) && start;

`ifdef GAP_SEQ_TIMEOUT_EN
  localparam int TO_W = gap_cnt_w(TIMEOUT_CYC);
  logic [TO_W-1:0] r_to_cnt;

  // Watchdog counts consecutive WAIT cycles; restarts on every entry to WAIT.
  always_ff @(posedge clock or posedge reset) begin
    if (reset)                 r_to_cnt <= '0;
    else if (r_state != WAIT)  r_to_cnt <= '0;
    else                       r_to_cnt <= r_to_cnt + 1'b1;
  end

  assign w_timeout = (r_state == WAIT) && !pool_done && (r_to_cnt == TO_W'(TIMEOUT_CYC - 1));
`else
  assign w_timeout = 1'b0;
`endif

  // State register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_next;
  end

  // Next-state and strobe outputs.
  always_comb begin
    w_next     = r_state;
    busy       = 1'b0;
    done       = 1'b0;
    pool_clear = 1'b0;
    mem_rd_en  = 1'b0;
    case (r_state)
      IDLE:   if (start) w_next = CLEAR;
      CLEAR: begin
        busy       = 1'b1;
        pool_clear = 1'b1;
        w_next     = FEED;
      end
      FEED: begin
        busy      = 1'b1;
        mem_rd_en = 1'b1;
        if (w_last_p) w_next = WAIT;
      end
      WAIT: begin
        busy = 1'b1;
        if (pool_done) begin
          w_next = EMIT;
        end else if (w_timeout) begin
          pool_clear = 1'b1;
          w_next     = IDLE;
        end
      end
      EMIT: begin
        busy = 1'b1;
        if (w_hs) w_next = w_last_ch ? FINISH : FEED;
      end
      FINISH: begin
        done   = 1'b1;
        w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  // Address, channel and point counters; address steps by one so no ch*P multiply is needed.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_addr <= '0;
      r_ch   <= '0;
      r_p    <= '0;
    end else if (w_accept || r_state == CLEAR) begin
      r_addr <= '0;
      r_ch   <= '0;
      r_p    <= '0;
    end else if (r_state == FEED) begin
      r_addr <= r_addr + 1'b1;
      r_p    <= w_last_p ? '0 : r_p + 1'b1;
    end else if (r_state == EMIT && w_hs && !w_last_ch) begin
      r_ch   <= r_ch + 1'b1;
      r_p    <= '0;
    end
  end

  // Sticky error: stray pool_done or watchdog expiry sets it, an accepted start clears it.
  always_ff @(posedge clock or posedge reset) begin
    if (reset)                              r_err <= 1'b0;
    else if (pool_done && r_state != WAIT)  r_err <= 1'b1;
    else if (w_timeout)                     r_err <= 1'b1;
    else if (w_accept)                      r_err <= 1'b0;
  end

  // Read data returns one cycle after the strobe; delay the strobe to qualify it.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) r_pt_valid <= 1'b0;
    else       r_pt_valid <= mem_rd_en;
  end

  assign err              = r_err;
  assign mem_rd_addr      = r_addr;
  assign pool_point_valid = r_pt_valid;
  // Gated so the point bus reads 0 whenever no point is in flight.
  assign pool_point_data  = r_pt_valid ? mem_rd_data : '0;

  gap_out_reg #(
    .DATA_WIDTH (DATA_WIDTH),
    .CH_WIDTH   (CH_W)
  ) u_out_reg (
    .i_clk     (clock),
    .i_rst     (reset),
    .i_load    (w_load),
    .i_data    (pool_average),
    .i_channel (r_ch),
    .i_ready   (out_ready),
    .o_valid   (out_valid),
    .o_data    (out_data),
    .o_channel (out_channel)
  );

endmodule

// File: tb/tb_gap_channel_sequencer.sv
// Self-checking bench for gap_channel_sequencer with a behavioural feature memory
// and avg_pool environment; expected averages are computed directly from memory.
module tb_gap_channel_sequencer;

  localparam int NCH  = 2;
  localparam int NPT  = 49;
  localparam int DW   = 32;
  localparam int AW   = 16;
  localparam int NMEM = NCH * NPT;

  logic          clock = 1'b0;
  logic          reset, start;
  logic          busy, done, err, mem_rd_en, pool_clear, pool_point_valid;
  logic [AW-1:0] mem_rd_addr;
  logic [DW-1:0] mem_rd_data, pool_point_data, pool_average, out_data;
  logic          pool_done, out_valid, out_ready;
  logic [0:0]    out_channel;

  always #5 clock = ~clock;

  gap_channel_sequencer #(
    .DATA_WIDTH    (DW),
    .ADDR_WIDTH    (AW),
    .NUM_CH        (NCH),
    .POINTS_PER_CH (NPT)
`ifdef GAP_SEQ_TIMEOUT_EN
    , .TIMEOUT_CYC (16)
`endif
  ) dut (
    .clock            (clock),
    .reset            (reset),
    .start            (start),
    .busy             (busy),
    .done             (done),
    .err              (err),
    .mem_rd_en        (mem_rd_en),
    .mem_rd_addr      (mem_rd_addr),
    .mem_rd_data      (mem_rd_data),
    .pool_clear       (pool_clear),
    .pool_point_data  (pool_point_data),
    .pool_point_valid (pool_point_valid),
    .pool_done        (pool_done),
    .pool_average     (pool_average),
    .out_valid        (out_valid),
    .out_ready        (out_ready),
    .out_data         (out_data),
    .out_channel      (out_channel)
  );

  int checks = 0;
  int errors = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Feature memory: one-cycle read latency.
  logic [DW-1:0] mem [NMEM];
  always @(posedge clock) if (mem_rd_en) mem_rd_data <= mem[mem_rd_addr];

  function automatic logic [DW-1:0] ref_avg(input int c);
    longint s = 0;
    for (int k = 0; k < NPT; k++) s += longint'(mem[c*NPT+k]);
    return DW'(s / NPT);
  endfunction

  // avg_pool environment: accumulates points, reports sum/NPT lat_cfg cycles later.
  longint        acc;
  int            n_pts, dly, lat_cfg;
  logic          done_m, suppress, inject;
  logic [DW-1:0] avg_m;
  always @(posedge clock or posedge reset) begin
    if (reset) begin
      acc <= 0; n_pts <= 0; dly <= 0; done_m <= 1'b0; avg_m <= '0;
    end else begin
      done_m <= 1'b0;
      if (pool_clear) begin
        acc <= 0; n_pts <= 0; dly <= 0;
      end else begin
        if (pool_point_valid) begin
          acc   <= acc + longint'(pool_point_data);
          n_pts <= n_pts + 1;
          if (n_pts == NPT - 1) dly <= lat_cfg;
        end
        if (dly != 0) begin
          dly <= dly - 1;
          if (dly == 1 && !suppress) begin
            done_m <= 1'b1;
            avg_m  <= DW'(acc / NPT);
            acc    <= 0;
            n_pts  <= 0;
          end
        end
      end
    end
  end
  assign pool_done    = done_m | inject;
  assign pool_average = avg_m;

  // Downstream ready: fixed level or random per cycle.
  logic rdy_mode, rdy_fix, rdy_rnd;
  assign out_ready = rdy_mode ? rdy_rnd : rdy_fix;
  initial begin
    rdy_rnd = 1'b1;
    forever begin
      @(posedge clock);
      #2 rdy_rnd = 1'($urandom_range(0, 1));
    end
  end

  // Monitor: read address order, emitted channel/average, done pulses.
  int            m_idx = 0, m_out = 0, n_reads = 0, n_done = 0;
  logic [DW-1:0] last_out [NCH];
  initial begin
    forever begin
      @(negedge clock);
      if (!reset) begin
        if (pool_clear) begin m_idx = 0; m_out = 0; end
        if (mem_rd_en) begin
          check_eq("rd_addr", 64'(mem_rd_addr), 64'(m_idx));
          m_idx++;
          n_reads++;
        end
        if (out_valid && out_ready) begin
          check_eq("out_channel", 64'(out_channel), 64'(m_out));
          check_eq("out_data", 64'(out_data), 64'(ref_avg(m_out)));
          if (m_out < NCH) last_out[m_out] = out_data;
          m_out++;
        end
        if (done) n_done++;
      end
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  int pass_r0, pass_d0;
  task automatic begin_pass();
    pass_r0 = n_reads;
    pass_d0 = n_done;
  endtask

  task automatic end_pass(input string tag);
    for (int i = 0; i < 5000 && busy; i++) tick();
    check_eq({tag, "_busy_end"}, 64'(busy), 64'(0));
    tick();
    check_eq({tag, "_done_cnt"}, 64'(n_done - pass_d0), 64'(1));
    check_eq({tag, "_reads"}, 64'(n_reads - pass_r0), 64'(NMEM));
    check_eq({tag, "_emitted"}, 64'(m_out), 64'(NCH));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    errors++;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $fatal(1);
  end

  logic [DW-1:0] hd;
  logic [0:0]    hc;
  logic          stable, noread, found;
  int            wc;

  initial begin
    reset = 1'b1; start = 1'b0; inject = 1'b0; suppress = 1'b0; lat_cfg = 2;
    rdy_mode = 1'b0; rdy_fix = 1'b1;
    for (int k = 0; k < NPT; k++) begin
      mem[k]     = 7;
      mem[NPT+k] = DW'(k);
    end
    repeat (3) @(posedge clock);
    #1;
    check_eq("rst_busy", 64'(busy), 64'(0));
    check_eq("rst_done", 64'(done), 64'(0));
    check_eq("rst_err", 64'(err), 64'(0));
    check_eq("rst_rd_en", 64'(mem_rd_en), 64'(0));
    check_eq("rst_addr", 64'(mem_rd_addr), 64'(0));
    check_eq("rst_clear", 64'(pool_clear), 64'(0));
    check_eq("rst_pt_valid", 64'(pool_point_valid), 64'(0));
    check_eq("rst_out_valid", 64'(out_valid), 64'(0));
    check_eq("rst_out_data", 64'(out_data), 64'(0));
    reset = 1'b0;
    tick();

    // Basic two-channel pass.
    begin_pass();
    pulse_start();
    check_eq("t1_clear", 64'(pool_clear), 64'(1));
    end_pass("t1");
    check_eq("t1_avg_ch0", 64'(last_out[0]), 64'(7));
    check_eq("t1_avg_ch1", 64'(last_out[1]), 64'(24));

    // Backpressure in EMIT.
    rdy_fix = 1'b0;
    begin_pass();
    pulse_start();
    for (int i = 0; i < 500 && !out_valid; i++) tick();
    check_eq("t2_valid", 64'(out_valid), 64'(1));
    hd = out_data; hc = out_channel; stable = 1'b1; noread = 1'b1;
    repeat (10) begin
      tick();
      if (!out_valid || out_data !== hd || out_channel !== hc) stable = 1'b0;
      if (mem_rd_en) noread = 1'b0;
    end
    check_eq("t2_stable", 64'(stable), 64'(1));
    check_eq("t2_noread", 64'(noread), 64'(1));
    check_eq("t2_hold_data", 64'(hd), 64'(ref_avg(0)));
    rdy_fix = 1'b1;
    tick();
    check_eq("t2_resume_rd_en", 64'(mem_rd_en), 64'(1));
    check_eq("t2_resume_addr", 64'(mem_rd_addr), 64'(NPT));
    end_pass("t2");

    // Start while busy is ignored.
    begin_pass();
    pulse_start();
    repeat (10) tick();
    pulse_start();
    check_eq("t3_busy", 64'(busy), 64'(1));
    check_eq("t3_rd_en", 64'(mem_rd_en), 64'(1));
    check_eq("t3_addr", 64'(mem_rd_addr), 64'(10));
    end_pass("t3");

    // Asynchronous reset at p=20 of channel 1, then restart.
    pulse_start();
    found = 1'b0;
    for (int i = 0; i < 500 && !found; i++) begin
      tick();
      if (mem_rd_en && mem_rd_addr == AW'(NPT + 20)) found = 1'b1;
    end
    check_eq("t4_reached", 64'(found), 64'(1));
    #2 reset = 1'b1;
    #1;
    check_eq("t4_busy", 64'(busy), 64'(0));
    check_eq("t4_rd_en", 64'(mem_rd_en), 64'(0));
    check_eq("t4_addr", 64'(mem_rd_addr), 64'(0));
    check_eq("t4_pt_valid", 64'(pool_point_valid), 64'(0));
    check_eq("t4_pt_data", 64'(pool_point_data), 64'(0));
    check_eq("t4_clear", 64'(pool_clear), 64'(0));
    check_eq("t4_out_valid", 64'(out_valid), 64'(0));
    @(posedge clock);
    #1 reset = 1'b0;
    tick();
    begin_pass();
    pulse_start();
    check_eq("t4_restart_clear", 64'(pool_clear), 64'(1));
    tick();
    check_eq("t4_restart_rd_en", 64'(mem_rd_en), 64'(1));
    check_eq("t4_restart_addr", 64'(mem_rd_addr), 64'(0));
    end_pass("t4");

    // Stray pool_done during FEED sets sticky err.
    begin_pass();
    pulse_start();
    repeat (5) tick();
    inject = 1'b1;
    tick();
    inject = 1'b0;
    check_eq("t5_err_set", 64'(err), 64'(1));
    check_eq("t5_busy", 64'(busy), 64'(1));
    end_pass("t5");
    check_eq("t5_err_sticky", 64'(err), 64'(1));
    begin_pass();
    pulse_start();
    check_eq("t5_err_cleared", 64'(err), 64'(0));
    end_pass("t5b");

    // Randomized passes: random data, divider latency and downstream ready.
    rdy_mode = 1'b1;
    for (int p = 0; p < 4; p++) begin
      for (int k = 0; k < NMEM; k++) mem[k] = DW'($urandom_range(0, 1000000));
      lat_cfg = int'($urandom_range(1, 6));
      begin_pass();
      pulse_start();
      end_pass("t6");
    end
    rdy_mode = 1'b0;

`ifdef GAP_SEQ_TIMEOUT_EN
    // Watchdog: suppress the divider result.
    suppress = 1'b1;
    begin_pass();
    pulse_start();
    found = 1'b0;
    for (int i = 0; i < 500 && !found; i++) begin
      tick();
      if (mem_rd_en && mem_rd_addr == AW'(NPT - 1)) found = 1'b1;
    end
    check_eq("t7_reached", 64'(found), 64'(1));
    tick();
    wc = 1;
    while (!pool_clear && wc < 100) begin
      tick();
      wc++;
    end
    check_eq("t7_wait_cycles", 64'(wc), 64'(16));
    check_eq("t7_busy_at_clear", 64'(busy), 64'(1));
    tick();
    check_eq("t7_busy", 64'(busy), 64'(0));
    check_eq("t7_err", 64'(err), 64'(1));
    tick();
    check_eq("t7_no_done", 64'(n_done - pass_d0), 64'(0));
    suppress = 1'b0;
`endif

    repeat (3) tick();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
